uart_scoreboard: RTL
====================

Name: uart_scoreboard

Overview:
Parametrised, cycle-accurate scoreboard for the UART FSM comparison benches. It replaces the single end-of-test error total with a synthesisable checker. The checker holds per-channel in-order queues of expected bytes and compares them against bytes observed from the DUT(s). It classifies and counts errors, runs a stall watchdog and produces a registered pass/fail verdict. It sits in the testbench between the stimulus driver, which pushes expected data, and the UART RX monitors, which push observed data. The bench's final banner reads its error counters.

Parameters:
N_CH, 2, number of independent channels (≥1); one per DUT encoding under comparison
DATA_W, 8, byte width compared
DEPTH, 16, expected-queue entries per channel (power of 2, ≥2)
TIMEOUT_CYC, 100000, cycles without progress before a watchdog error (≥1)
CNT_W, 16, width of every error/match counter; saturating

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
exp_valid  in  1  push expected byte
exp_ch  in  $clog2(N_CH) (min 1)  channel of expected byte
exp_data  in  DATA_W  expected byte
exp_ready  out  1  target channel's queue not full (combinational from exp_ch)
act_valid  in  1  observed byte from DUT monitor
act_ch  in  $clog2(N_CH) (min 1)  channel of observed byte
act_data  in  DATA_W  observed byte
end_of_test  in  1  one-cycle pulse: stimulus finished
match_count  out  CNT_W  total correct compares
mismatch_count  out  CNT_W  data-mismatch errors
unexpected_count  out  CNT_W  act on empty queue
overflow_count  out  CNT_W  exp push on full queue
timeout_err  out  1  watchdog fired (sticky)
done  out  1  verdict valid (sticky until rst)
pass  out  1  valid when done: all error counts 0, timeout_err 0, all queues empty

Behaviour:
- Reset: all queues empty. All counters 0. timeout_err, done and pass 0. State IDLE.
- States: IDLE → RUN on the first exp_valid or act_valid. RUN → DRAIN on end_of_test. DRAIN → DONE when all queues are empty or the watchdog fires. DONE is absorbing. end_of_test in IDLE goes directly to DRAIN.
- Push: if exp_valid and queue[exp_ch] is not full, write at the tail (visible next cycle). If full, drop the byte and increment overflow_count.
- Compare: on act_valid, check queue[act_ch]:
  - Non-empty: pop the head. Equal → match_count+1. Unequal → mismatch_count+1.
  - Empty: unexpected_count+1. No pop.
- Same-cycle push and act on the same channel:
  - Queue empty: the act is unexpected; the push still lands. There is no bypass.
  - Queue full and non-empty: the pop frees a slot. The push is accepted, not an overflow.
- Different channels act independently in the same cycle.
- Counters saturate at 2^CNT_W−1. They do not wrap.
- Watchdog: counts cycles in RUN/DRAIN while any queue is non-empty and no act_valid is seen. It resets to 0 on any act_valid. At TIMEOUT_CYC it sets timeout_err and forces DRAIN → DONE. In RUN it only flags.
- Entering DONE: done=1 and pass is computed that cycle, so both are registered, 1-cycle latency from the final pop. After DONE, inputs are ignored and counters are frozen.
- exp_ch/act_ch ≥ N_CH: the input is ignored and unexpected_count+1 (act) or overflow_count+1 (exp).
- Mid-operation rst: clears everything in one cycle, discarding queue contents.

Decomposition:
- Package uart_sb_pkg:
  - sb_state_e enum {IDLE, RUN, DRAIN, DONE}
  - sb_err_e enum {ERR_MISMATCH, ERR_UNEXPECTED, ERR_OVERFLOW, ERR_TIMEOUT}
  - function sat_inc for saturating increment
- Sub-module sb_fifo (DATA_W, DEPTH): sync FIFO with push/pop/full/empty/head. Pointers carry an extra wrap bit. Simultaneous push/pop while full is allowed. Instantiate it N_CH times in a generate loop.

Test Plan:
- N_CH=2: push 0x55,0xA3 on ch0 and 0x0F on ch1. Act the same bytes, interleaved. Pulse end_of_test → match_count=3, all errors 0, done=1, pass=1.
- Push 0x41 on ch0, act 0x42 on ch0 → mismatch_count=1, queue empty. After end_of_test, pass=0.
- Act 0x7E on ch1 with its queue empty → unexpected_count=1, no state change on ch0. A same-cycle push of 0x7E to ch1 lands, so the queue holds 1 entry.
- DEPTH=16: push 17 bytes to ch0 → exp_ready low after the 16th, overflow_count=1. Then push and act in the same cycle while full → no overflow, occupancy stays 16.
- TIMEOUT_CYC=50: push 1 byte and pulse end_of_test, with no act → timeout_err=1 and done=1 exactly 50 cycles into the stall, pass=0.
- Assert rst mid-stream with 5 entries queued → all counters 0, done=0. A subsequent 1-byte exchange gives pass=1.

Source files
------------

// File: rtl/uart_sb_pkg.sv
// Shared types and helpers for the UART comparison scoreboard.
package uart_sb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sb_state_e;

  typedef enum logic [1:0] {
    ERR_MISMATCH,
    ERR_UNEXPECTED,
    ERR_OVERFLOW,
    ERR_TIMEOUT
  } sb_err_e;

  // Saturating increment; callers widen to 32 bits and truncate back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/uart_scoreboard_fifo.sv
// In-order expected-byte queue for one scoreboard channel.
module sb_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en, rd_en;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot the push writes, so push-while-full is legal with a pop.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_scoreboard.sv
// Multi-channel in-order scoreboard: classifies compare errors, runs a stall
// watchdog and latches a pass/fail verdict once the drain completes.
module uart_scoreboard
  import uart_sb_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   exp_valid,
  input  logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0] exp_ch,
  input  logic [DATA_W-1:0]                      exp_data,
  output logic                                   exp_ready,
  input  logic                                   act_valid,
  input  logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0] act_ch,
  input  logic [DATA_W-1:0]                      act_data,
  input  logic                                   end_of_test,
  output logic [CNT_W-1:0]                       match_count,
  output logic [CNT_W-1:0]                       mismatch_count,
  output logic [CNT_W-1:0]                       unexpected_count,
  output logic [CNT_W-1:0]                       overflow_count,
  output logic                                   timeout_err,
  output logic                                   done,
  output logic                                   pass
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0]     CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  sb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  err_cnt_q [3];
  logic [CNT_W-1:0]  err_cnt_d [3];
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [N_CH-1:0]   full, empty, push, pop, empty_next;
  logic [DATA_W-1:0] head [N_CH];
  logic [LVL_W-1:0]  level [N_CH];
  logic [DATA_W-1:0] act_head;
  logic [3:0]        err_hit;
  logic              active, exp_in_range, act_in_range;
  logic              match_hit, stall, wd_fire;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[c]),
      .data_i  (exp_data),
      .pop_i   (pop[c]),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .head_o  (head[c]),
      .level_o (level[c])
    );
  end

  assign active       = (state_q != DONE);
  assign exp_in_range = (32'(exp_ch) < 32'(N_CH));
  assign act_in_range = (32'(act_ch) < 32'(N_CH));

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    push       = '0;
    pop        = '0;
    empty_next = '0;
    act_head   = '0;
    exp_ready  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      pop[c]  = active && act_valid && act_in_range &&
                (32'(act_ch) == 32'(c)) && !empty[c];
      push[c] = active && exp_valid && exp_in_range &&
                (32'(exp_ch) == 32'(c)) && (!full[c] || pop[c]);
      empty_next[c] = !push[c] &&
                      (empty[c] || (pop[c] && level[c] == LVL_W'(1)));
      if (32'(act_ch) == 32'(c)) act_head  = head[c];
      if (32'(exp_ch) == 32'(c)) exp_ready = !full[c];
    end
  end

  // The watchdog saturates at its last count so a RUN-phase timeout still
  // forces DONE immediately once DRAIN is reached with the stall ongoing.
  assign stall   = ((state_q == RUN) || (state_q == DRAIN)) && !(&empty) && !act_valid;
  assign wd_fire = stall && (wd_q == WD_LAST);
  assign wd_d    = !stall ? '0 : (wd_fire ? wd_q : wd_q + WD_W'(1));

  assign match_hit                = (|pop) && (act_head == act_data);
  assign err_hit[ERR_MISMATCH]    = (|pop) && (act_head != act_data);
  assign err_hit[ERR_UNEXPECTED]  = active && act_valid && !(|pop);
  assign err_hit[ERR_OVERFLOW]    = active && exp_valid && !(|push);
  assign err_hit[ERR_TIMEOUT]     = wd_fire;

  always_comb begin
    match_d   = match_hit ? CNT_W'(sat_inc(32'(match_q), CNT_MAX)) : match_q;
    for (int i = 0; i < 3; i++) begin
      err_cnt_d[i] = err_hit[i] ? CNT_W'(sat_inc(32'(err_cnt_q[i]), CNT_MAX))
                                : err_cnt_q[i];
    end
    timeout_d = timeout_q | err_hit[ERR_TIMEOUT];
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (end_of_test)                 state_d = DRAIN;
        else if (exp_valid || act_valid) state_d = RUN;
      end
      RUN:   if (end_of_test) state_d = DRAIN;
      DRAIN: if ((&empty_next) || wd_fire) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Verdict uses next-cycle counters and occupancy so it lands with DONE.
    if (state_q != DONE && state_d == DONE) begin
      done_d = 1'b1;
      pass_d = (err_cnt_d[ERR_MISMATCH]   == '0) &&
               (err_cnt_d[ERR_UNEXPECTED] == '0) &&
               (err_cnt_d[ERR_OVERFLOW]   == '0) &&
               !timeout_d && (&empty_next);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      match_q   <= '0;
      err_cnt_q <= '{default: '0};
      wd_q      <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      err_cnt_q <= err_cnt_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign match_count      = match_q;
  assign mismatch_count   = err_cnt_q[ERR_MISMATCH];
  assign unexpected_count = err_cnt_q[ERR_UNEXPECTED];
  assign overflow_count   = err_cnt_q[ERR_OVERFLOW];
  assign timeout_err      = timeout_q;
  assign done             = done_q;
  assign pass             = pass_q;

endmodule
